// File: rtl/addsub_pipe.sv
// Segmented add/subtract pipeline: SEG_W bits per stage with skew/deskew registers,
// valid/ready handshake with a single global advance enable, registered NZCV flags.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int STAGES = WIDTH / SEG_W;

  logic             w_en;
  logic [WIDTH-1:0] w_ca;
  logic [WIDTH-1:0] w_cb;
  logic             w_c0;

  assign w_en     = !out_valid || out_ready;
  // Held low during reset so nothing is taken while the pipe is being cleared.
  assign in_ready = w_en && rst_n;

  always_comb begin
    w_ca = a;
    w_cb = b;
    w_c0 = 1'b0;
    case (op)
      2'b01:   begin w_cb = ~b; w_c0 = 1'b1; end
      2'b10:   begin w_ca = ~a; w_c0 = 1'b1; end
      2'b11:   w_c0 = cin;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic             w_c_in;
    logic             w_vld_in;
    logic [SEG_W-1:0] w_lo;
    logic [1:0]       w_hi;
    logic [WIDTH-1:0] w_sum_nx;
    logic [WIDTH-1:0] r_sum;
    logic             r_vld;

    if (gi == 0) begin : g_first
      assign w_a_in   = w_ca;
      assign w_b_in   = w_cb;
      assign w_sum_in = '0;
      assign w_c_in   = w_c0;
      assign w_vld_in = in_valid;
    end else begin : g_mid
      assign w_a_in   = g_stage[gi-1].g_skew.r_a;
      assign w_b_in   = g_stage[gi-1].g_skew.r_b;
      assign w_sum_in = g_stage[gi-1].r_sum;
      assign w_c_in   = g_stage[gi-1].g_skew.r_c;
      assign w_vld_in = g_stage[gi-1].r_vld;
    end

    // Split off the segment MSB so the carry into it is visible for overflow.
    assign w_lo = {1'b0, w_a_in[gi*SEG_W +: SEG_W-1]}
                + {1'b0, w_b_in[gi*SEG_W +: SEG_W-1]}
                + SEG_W'(w_c_in);
    assign w_hi = 2'(w_a_in[gi*SEG_W+SEG_W-1]) + 2'(w_b_in[gi*SEG_W+SEG_W-1])
                + 2'(w_lo[SEG_W-1]);

    always_comb begin
      w_sum_nx = w_sum_in;
      w_sum_nx[gi*SEG_W +: SEG_W] = {w_hi[0], w_lo[SEG_W-2:0]};
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_sum <= '0;
      end else if (w_en) begin
        r_vld <= w_vld_in;
        r_sum <= w_sum_nx;
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic             r_c;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_c <= 1'b0;
        end else if (w_en) begin
          r_a <= w_a_in;
          r_b <= w_b_in;
          r_c <= w_hi[1];
        end
      end
    end else begin : g_last
      logic [3:0] r_flags;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_flags <= '0;
        end else if (w_en) begin
          r_flags <= {w_sum_nx[WIDTH-1], (w_sum_nx == '0), w_hi[1], w_hi[1] ^ w_lo[SEG_W-1]};
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign result    = g_stage[STAGES-1].r_sum;
  assign flags     = g_stage[STAGES-1].g_last.r_flags;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and random checks of addsub_pipe: handshake, latency, flags,
// backpressure and mid-stream reset, with a queue of expected beats.
module tb_addsub_pipe;
  localparam int W      = 32;
  localparam int SEG    = 8;
  localparam int STAGES = W / SEG;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cin;
  logic [W-1:0] a, b, result;
  logic [1:0]   op;
  logic [3:0]   flags;

  logic         in_valid16, in_ready16, out_valid16;
  logic [15:0]  a16, b16, result16;
  logic [3:0]   flags16;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  exp_t         sb[$];
  logic [W-1:0] nxt_r;
  logic [3:0]   nxt_f;
  bit           nxt_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_pipe #(.WIDTH(W), .SEG_W(SEG)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  addsub_pipe #(.WIDTH(16), .SEG_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(2'b00), .cin(1'b0), .out_valid(out_valid16),
    .out_ready(1'b1), .result(result16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: conditioned operands, 33-bit sum, overflow from operand/result signs.
  function automatic logic [W+3:0] model(input logic [W-1:0] x0, input logic [W-1:0] y0,
                                         input logic [1:0] o, input logic ci);
    logic [W-1:0] x, y;
    logic         c, v;
    logic [W:0]   s;
    x = x0; y = y0; c = 1'b0;
    case (o)
      2'b01:   begin y = ~y0; c = 1'b1; end
      2'b10:   begin x = ~x0; c = 1'b1; end
      2'b11:   c = ci;
      default: ;
    endcase
    s = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {s[W-1], (s[W-1:0] == '0), s[W], v, s[W-1:0]};
  endfunction

  // One clock: evaluate the handshake at the falling edge, then advance.
  task automatic step(output bit accepted);
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back('{r: nxt_r, f: nxt_f, acc: cyc, lat: nxt_lat});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("stale_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("[TB] beat out result=%h flags=%b expected %h/%b", result, flags, e.r, e.f);
        check("result", 64'(result), 64'(e.r));
        check("flags", 64'(flags), 64'(e.f));
        if (e.lat) check("latency", 64'(cyc - e.acc), 64'(STAGES));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] xo,
                      input logic xc, input logic [W-1:0] er, input logic [3:0] ef, input bit lat);
    bit acc;
    a = xa; b = xb; op = xo; cin = xc; in_valid = 1'b1;
    nxt_r = er; nxt_f = ef; nxt_lat = lat;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step(acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic rnd_beat(output logic [W-1:0] ra, output logic [W-1:0] rb,
                          output logic [1:0] ro, output logic rc);
    logic [W+3:0] m;
    ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3)); rc = 1'($urandom_range(0, 1));
    m = model(ra, rb, ro, rc);
    a = ra; b = rb; op = ro; cin = rc; in_valid = 1'b1;
    nxt_r = m[W-1:0]; nxt_f = m[W+3:W]; nxt_lat = 1'b0;
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] ra, rb, held_r;
    logic [3:0]   held_f;
    logic [1:0]   ro;
    logic         rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0;
    nxt_r = '0; nxt_f = '0; nxt_lat = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed vectors; cin=1 on the first ADD must be ignored
    send(32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b1, 32'h0000_0100, 4'b0000, 1'b1);
    drain();
    send(32'd5, 32'd5, 2'b01, 1'b0, 32'h0000_0000, 4'b0110, 1'b1);
    send(32'd0, 32'd1, 2'b01, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0, 32'h8000_0000, 4'b1001, 1'b0);
    send(32'd1, 32'h8000_0000, 2'b10, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b0);
    send(32'hFFFF_FFFF, 32'd0, 2'b11, 1'b1, 32'h0000_0000, 4'b0110, 1'b0);
    send(32'hFFFF_FFFF, 32'd0, 2'b11, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    drain();

    // Backpressure: 10 random beats, out_ready dropped for 3 cycles mid-stream
    for (int i = 0; i < 10; i++) begin
      rnd_beat(ra, rb, ro, rc);
      if (i == 6) begin
        out_ready = 1'b0;
        #1;
        held_r = result; held_f = flags;
        for (int s = 0; s < 3; s++) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          step(acc);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_result_held", 64'(result), 64'(held_r));
          check("stall_flags_held", 64'(flags), 64'(held_f));
        end
        out_ready = 1'b1;
        #1;
      end
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step(acc);
      a = ~a; op = ~op; cin = ~cin;  // later changes must not touch the accepted beat
    end
    drain();

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      rnd_beat(ra, rb, ro, rc);
      step(acc);
    end
    rnd_beat(ra, rb, ro, rc);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    step(acc);
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) step(acc);
    check("midrst_no_stale", 64'(out_valid), 64'd0);

    // Single-stage instance: latency 1
    a16 = 16'h00FF; b16 = 16'h0001; in_valid16 = 1'b1;
    #1;
    check("w16_in_ready", 64'(in_ready16), 64'd1);
    check("w16_pre_valid", 64'(out_valid16), 64'd0);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    $display("[TB] w16 beat out result=%h flags=%b", result16, flags16);
    check("w16_out_valid", 64'(out_valid16), 64'd1);
    check("w16_result", 64'(result16), 64'h0100);
    check("w16_flags", 64'(flags16), 64'd0);
    @(posedge clk); #1;
    check("w16_bubble", 64'(out_valid16), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
